// File: rtl/tick_tx_pkg.sv
// Shared types for the tick-paced serial transmitter.
package tick_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tick_serial_tx.sv
// Tick-paced serial frame transmitter: start bit, DATA_W bits LSB-first, STOP_BITS stop bits.
// Each line level lasts one tick interval; tx and frame_done come straight from flops.
module tick_serial_tx
    import tick_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned STOP_W = 2;

    if (DATA_W < 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("tick_serial_tx: DATA_W must be >= 2 and STOP_BITS must be 1 or 2");
    end

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [STOP_W-1:0] stop_cnt;
    logic              accept;

    // Ready is forced low while reset is asserted, independent of the clock.
    assign data_ready = (state == IDLE) && !rst;
    assign accept     = data_valid && data_ready;

    // Next line level is computed alongside the state so tx is a plain flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            tx         <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (accept) begin
                        shift_reg <= data_in;
                        bit_cnt   <= '0;
                        stop_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (tick) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        tx      <= shift_reg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            // Counter holds at its last value so it never wraps.
                            tx    <= IDLE_LEVEL;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt == STOP_W'(STOP_BITS - 1)) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= IDLE_LEVEL;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_serial_tx.sv
// Scoreboard bench for tick_serial_tx: stimulus queues expected frames, a negedge monitor checks the line.
module tb_tick_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tick0, valid0, ready0, tx0, busy0, fd0;
    logic [7:0] din0;
    logic       tick1, valid1, ready1, tx1, busy1, fd1;
    logic [6:0] din1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] bits;
        int          nb;
        int          bc;
        int          arm;
    } exp_t;

    exp_t exp_q [2][$];
    logic samp  [2][$];

    int tper0 = 0, tper1 = 0, tc0 = 0, tc1 = 0;

    tick_serial_tx #(.DATA_W(8), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tick(tick0), .data_in(din0), .data_valid(valid0),
        .data_ready(ready0), .tx(tx0), .busy(busy0), .frame_done(fd0)
    );

    tick_serial_tx #(.DATA_W(7), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick1), .data_in(din1), .data_valid(valid1),
        .data_ready(ready1), .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    // Periodic tick sources; period 1 holds tick high, period 0 disables it.
    always @(posedge clk) begin
        #1;
        tc0   = (tc0 + 1 >= tper0) ? 0 : tc0 + 1;
        tick0 = (tper0 != 0) && (tc0 == 0);
        tc1   = (tc1 + 1 >= tper1) ? 0 : tc1 + 1;
        tick1 = (tper1 != 0) && (tc1 == 0);
    end

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic mon_step(input int i, input logic t, input logic b, input logic fd);
        exp_t e;
        int   n;
        int   base;
        logic all1;
        if (rst) begin
            if (samp[i].size() != 0) begin
                chk("abort_no_done", int'(fd), 0);
                samp[i].delete();
            end
        end else if (b) begin
            samp[i].push_back(t);
        end else if (samp[i].size() != 0) begin
            chk("done_pulse", int'(fd), 1);
            if (exp_q[i].size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame: got a frame on dut%0d, expected none", i);
            end else begin
                e = exp_q[i].pop_front();
                n = samp[i].size();
                chk($sformatf("frame_cycles_dut%0d", i), n, e.arm + e.nb * e.bc);
                all1 = 1'b1;
                for (int k = 0; k < e.arm && k < n; k++)
                    if (samp[i][k] !== 1'b1) all1 = 1'b0;
                chk("arm_idle_level", int'(all1), 1);
                for (int j = 0; j < e.nb; j++) begin
                    base = e.arm + j * e.bc;
                    if (base + e.bc - 1 < n) begin
                        chk($sformatf("dut%0d_bit%0d_first", i, j), int'(samp[i][base]), int'(e.bits[j]));
                        chk($sformatf("dut%0d_bit%0d_last", i, j), int'(samp[i][base + e.bc - 1]),
                            int'(e.bits[j]));
                    end
                end
            end
            samp[i].delete();
        end else begin
            chk("idle_no_done", int'(fd), 0);
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, tx0, busy0, fd0);
        mon_step(1, tx1, busy1, fd1);
    end

    task automatic wait_tick(input int i);
        for (int k = 0; k < 20; k++) begin
            if ((i == 0) ? tick0 : tick1) break;
            @(posedge clk);
            #2;
        end
    endtask

    // Offers d in a tick cycle and returns just after the acceptance edge.
    task automatic send(input int i, input logic [7:0] d, input logic [15:0] bits,
                        input int nb, input int bc, input int arm, input logic do_push);
        exp_t e;
        logic ok;
        wait_tick(i);
        if (i == 0) begin
            valid0 = 1'b1;
            din0   = d;
        end else begin
            valid1 = 1'b1;
            din1   = d[6:0];
        end
        e.bits = bits;
        e.nb   = nb;
        e.bc   = bc;
        e.arm  = arm;
        if (do_push) exp_q[i].push_back(e);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((i == 0) ? ready0 : ready1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance on dut%0d, expected one", i);
        end
        @(posedge clk);
        #2;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && !busy0 && !busy1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got pending frames, expected none");
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   k;
        rst = 1'b1;
        tick0 = 1'b0; tick1 = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0;
        din0 = '0; din1 = '0;

        // Reset state and ticks ignored while idle
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx", int'(tx0), 1);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(fd0), 0);
        chk("rst_ready", int'(ready0), 0);
        chk("rst_tx_dut1", int'(tx1), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", int'(ready0), 1);
        tper0 = 1;
        repeat (6) begin
            @(posedge clk);
            #2;
            chk("idle_tick_tx", int'(tx0), 1);
            chk("idle_tick_busy", int'(busy0), 0);
        end

        // Continuous tick, 0x00: one ARM cycle then one cycle per bit
        send(0, 8'h00, 16'h0200, 10, 1, 1, 1'b1);
        drain();

        // Tick every 4 cycles, 0xA5
        tper0 = 4;
        repeat (5) @(posedge clk);
        #2;
        send(0, 8'hA5, 16'h034A, 10, 4, 4, 1'b1);
        drain();

        // Valid held with data_in changing; re-acceptance only in the frame_done cycle
        wait_tick(0);
        valid0 = 1'b1;
        din0   = 8'h3C;
        e.bits = 16'h0278; e.nb = 10; e.bc = 4; e.arm = 4;
        exp_q[0].push_back(e);
        @(negedge clk);
        chk("accept_3c_ready", int'(ready0), 1);
        @(posedge clk);
        #2;
        for (k = 1; k <= 100; k++) begin
            din0 = 8'(k * 37 + 11);
            @(negedge clk);
            if (ready0) break;
            @(posedge clk);
            #2;
        end
        chk("reaccept_cycle", k, 45);
        e.bits = {6'b0, 1'b1, din0, 1'b0}; e.nb = 10; e.bc = 4; e.arm = 3;
        exp_q[0].push_back(e);
        @(posedge clk);
        #2;
        valid0 = 1'b0;
        drain();

        // Reset during DATA bit 3 of 0xF0, then 0x81 intact
        send(0, 8'hF0, 16'h0000, 10, 4, 4, 1'b0);
        repeat (21) @(posedge clk);
        #2;
        chk("abort_pre_tx", int'(tx0), 0);
        rst = 1'b1;
        #1;
        chk("abort_tx", int'(tx0), 1);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_done", int'(fd0), 0);
        chk("abort_ready", int'(ready0), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("release_ready", int'(ready0), 1);
        chk("release_busy", int'(busy0), 0);
        send(0, 8'h81, 16'h0302, 10, 4, 4, 1'b1);
        drain();

        // DATA_W=7, STOP_BITS=2, tick every 3 cycles, 0x55
        tper1 = 3;
        repeat (5) @(posedge clk);
        #2;
        send(1, 8'h55, 16'h03AA, 10, 3, 3, 1'b1);
        drain();

        chk("scoreboard_empty", exp_q[0].size() + exp_q[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_serial_tx.md
# tick_serial_tx

- Tick-paced serial frame transmitter.
- Sits directly downstream of the programmable period counter and consumes its one-cycle enable as a bit-rate tick.
- Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first on a single line, framed by one start bit (0) and STOP_BITS stop bits (1).
- Each bit lasts exactly one tick interval.

## Interface
Parameters:
- DATA_W, default 8: payload bits per frame, must be ≥2.
- STOP_BITS, default 1: stop bits per frame, 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  bit-rate enable from the period counter; one or more clk wide; may be held high continuously.
- data_in  input  DATA_W  payload; sampled only on acceptance.
- data_valid  input  1  payload offered.
- data_ready  output  1  block can accept; data_valid && data_ready = acceptance.
- tx  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last stop bit completes.

## Operation
- State machine with five states:
  - IDLE: data_ready=1. On acceptance: capture data_in into shift register, clear bit and stop counters, go to ARM. Ticks in IDLE are ignored.
  - ARM: tx=1, wait for tick. On tick: go to START. Aligns the start bit to a full tick interval. A tick coincident with the acceptance cycle is not seen by ARM.
  - START: tx=0. On tick: go to DATA with bit counter=0.
  - DATA: tx=shift_reg[0]. On tick:
    - shift right and increment the bit counter;
    - after the tick with counter=DATA_W-1, go to STOP.
  - STOP: tx=1. On tick: increment stop counter. After STOP_BITS ticks: go to IDLE and assert frame_done for that one cycle.
- Output rules:
  - data_ready = (state==IDLE) && !rst, so it is 0 while reset is held.
  - busy = (state!=IDLE).
  - tx and frame_done are registered outputs, not decoded combinationally, so they are glitch-free.
- Bit counter width is $clog2(DATA_W). Counters never wrap mid-frame.
- Captured data is immune to data_in and data_valid changes after acceptance. No acceptance occurs outside IDLE.

## Timing
Reset values (asynchronous, effective immediately while rst=1):
- state=IDLE, tx=1, busy=0, frame_done=0, data_ready=0, shift register=0.

Reset mid-frame:
- tx returns to 1 immediately.
- The frame is aborted and no frame_done pulse is generated.
- The first rising edge after release sees IDLE.

Latency and frame length:
- From acceptance edge to tx falling: first tick seen in ARM plus one edge.
- Frame length from START entry = (1+DATA_W+STOP_BITS) tick intervals.

Continuous tick (period 1):
- Every state advances each cycle.
- Acceptance → 1 cycle in ARM → 1 cycle per bit.

frame_done:
- Rises on the edge that leaves STOP, concurrent with busy falling and data_ready rising.
- Back-to-back frames: the next acceptance can happen in that same cycle, giving zero idle bits between frames apart from the ARM wait.

Multi-cycle tick:
- A tick held for N cycles advances N states/bits; upstream must guarantee single-cycle pulses unless the period is 1.

## Structure
- Shared package tick_tx_pkg holds:
  - the state enum typedef: IDLE, ARM, START, DATA, STOP, 3-bit encoding;
  - the localparam for the idle line level (1).
- Single module. No sub-module is natural; the FSM, shift register and two counters stay together.
- The top level instantiates it next to the period counter, with en driving tick.

## Test plan
- Reset: hold rst=1 → tx=1, busy=0, frame_done=0, data_ready=0. Release → data_ready=1 on the next cycle. Ticks in IDLE leave tx=1.
- Tick every 4 cycles, send 0xA5 → tx = 0 then 1,0,1,0,0,1,0,1 then 1, each level lasting 4 cycles. busy high throughout; exactly one frame_done pulse.
- tick held high, send 0x00 → ARM for 1 cycle, then tx low for 9 consecutive cycles, then high for 1. frame_done 11 cycles after acceptance.
- data_valid held high with data_in changed every cycle during a 0x3C frame:
  - output matches 0x3C;
  - the next acceptance occurs only in the frame_done cycle, capturing that cycle's data_in.
- rst pulsed during DATA bit 3 → tx=1 in the same cycle with no frame_done. After release, 0x81 is sent intact.
- STOP_BITS=2, DATA_W=7, tick every 3 cycles, send 0x55 → 7 data bits, then stop high for 6 cycles before frame_done.
